// File: rtl/array_divider_4b.sv
// array_divider_4b: 4-bit signed divider, one clock of latency.
// Operands are registered on a start strobe. A 4-row restoring array then
// works on the operand magnitudes, and the signed result loads on the next edge.
// Optional feature: define ARRAY_DIVIDER_REMAINDER_EN to build port R and its register.
//
// Handshake: there is no ready signal. The block accepts every start.
// When ctrl_DIV is 1 at a rising edge, that edge captures the operands.
// data_resultRDY is then 1 for exactly the following cycle, and in that cycle
// Q, R and data_exception hold the result. Starts on consecutive edges
// pipeline, so each one gets its own pulse one cycle later.
module array_divider_4b (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       ctrl_DIV,
  input  logic [3:0] data_operandA,
  input  logic [3:0] data_operandB,
  output logic [3:0] Q,
`ifdef ARRAY_DIVIDER_REMAINDER_EN
  output logic [3:0] R,
`endif
  output logic       data_resultRDY,
  output logic       data_exception
);

  logic [3:0] op_a;
  logic [3:0] op_b;
  logic       pending;

  logic       sign_a;
  logic       sign_b;
  logic [3:0] a_mag;
  logic [3:0] b_mag;
  logic [3:0] q_mag;
  logic [3:0] part;
  logic [4:0] shifted;
  logic       borrow;
  logic       div_zero;
  logic       overflow;
  logic [3:0] q_signed;
  logic [3:0] q_next;
  logic       exc_next;

  // Operand magnitudes. An input of -8 gives 4'b1000, read as unsigned 8.
  always_comb begin
    sign_a = op_a[3];
    sign_b = op_b[3];
    a_mag  = sign_a ? (~op_a + 4'd1) : op_a;
    b_mag  = sign_b ? (~op_b + 4'd1) : op_b;
  end

  // Restoring array: each row shifts in one dividend bit and subtracts only
  // if there is no borrow. The partial remainder stays below |B| <= 8, so 4 bits hold it.
  always_comb begin
    part    = 4'd0;
    q_mag   = 4'd0;
    shifted = 5'd0;
    borrow  = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      shifted  = {part, a_mag[i]};
      borrow   = (shifted < {1'b0, b_mag});
      q_mag[i] = ~borrow;
      part     = borrow ? shifted[3:0] : (shifted[3:0] - b_mag);
    end
  end

  // Apply signs and override the two exceptional operand pairs.
  always_comb begin
    div_zero = (op_b == 4'd0);
    overflow = (op_a == 4'b1000) && (op_b == 4'b1111);
    q_signed = (sign_a ^ sign_b) ? (~q_mag + 4'd1) : q_mag;
    exc_next = div_zero | overflow;
    if (div_zero)      q_next = 4'd0;
    else if (overflow) q_next = 4'b1000;
    else               q_next = q_signed;
  end

  // Capture operands on start. One cycle later, load the quotient and status.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      op_a           <= 4'd0;
      op_b           <= 4'd0;
      pending        <= 1'b0;
      Q              <= 4'd0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else begin
      pending        <= ctrl_DIV;
      data_resultRDY <= pending;
      if (ctrl_DIV) begin
        op_a <= data_operandA;
        op_b <= data_operandB;
      end
      if (pending) begin
        Q              <= q_next;
        data_exception <= exc_next;
      end
    end
  end

`ifdef ARRAY_DIVIDER_REMAINDER_EN
  logic [3:0] r_next;

  // The remainder takes the dividend's sign. The exceptional pairs are forced.
  always_comb begin
    if (div_zero)      r_next = op_a;
    else if (overflow) r_next = 4'd0;
    else               r_next = sign_a ? (~part + 4'd1) : part;
  end

  // The remainder register loads alongside Q.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)     R <= 4'd0;
    else if (pending) R <= r_next;
  end
`endif

endmodule

// File: tb/tb_array_divider_4b.sv
// tb_array_divider_4b: directed test of array_divider_4b.
// R is checked only when ARRAY_DIVIDER_REMAINDER_EN is defined.
module tb_array_divider_4b;

  logic       clock;
  logic       reset_n;
  logic       ctrl_DIV;
  logic [3:0] data_operandA;
  logic [3:0] data_operandB;
  logic [3:0] Q;
  logic       data_resultRDY;
  logic       data_exception;
`ifdef ARRAY_DIVIDER_REMAINDER_EN
  logic [3:0] R;
`endif

  int checks = 0;
  int errors = 0;
  logic [8:0] exp_q[$];  // {exception, quotient, remainder}

  array_divider_4b dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .Q              (Q),
`ifdef ARRAY_DIVIDER_REMAINDER_EN
    .R              (R),
`endif
    .data_resultRDY (data_resultRDY),
    .data_exception (data_exception)
  );

  // Clock and reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Scoreboard primitives
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_result(input string tag, input logic rdy, input logic [3:0] q,
                              input logic [3:0] r, input logic exc);
    check({tag, " rdy"}, 32'(data_resultRDY), 32'(rdy));
    check({tag, " Q"},   32'(Q), 32'(q));
    check({tag, " exc"}, 32'(data_exception), 32'(exc));
`ifdef ARRAY_DIVIDER_REMAINDER_EN
    check({tag, " R"},   32'(R), 32'(r));
`else
    if (r === 4'bxxxx) $display("note: remainder %s unused", tag);
`endif
  endtask

  // Independent reference: the language's truncating divide, plus the exceptional pairs
  function automatic logic [8:0] model(input logic [3:0] a, input logic [3:0] b);
    int ai, bi, qi, ri;
    logic exc;
    ai = int'($signed(a));
    bi = int'($signed(b));
    if (bi == 0) begin
      qi = 0; ri = ai; exc = 1'b1;
    end else if (ai == -8 && bi == -1) begin
      qi = -8; ri = 0; exc = 1'b1;
    end else begin
      qi = ai / bi; ri = ai % bi; exc = 1'b0;
    end
    return {exc, qi[3:0], ri[3:0]};
  endfunction

  // Driver tasks
  task automatic do_one(input string tag, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] q, input logic [3:0] r, input logic exc);
    @(negedge clock);
    ctrl_DIV = 1'b1; data_operandA = a; data_operandB = b;
    @(negedge clock);
    ctrl_DIV = 1'b0;
    @(negedge clock);
    check_result(tag, 1'b1, q, r, exc);
  endtask

  initial begin
    logic [8:0] e;
    logic [7:0] ab;
    ctrl_DIV = 1'b0; data_operandA = 4'd0; data_operandB = 4'd0;
    reset_n = 1'b0;
    #12;
    check_result("reset", 1'b0, 4'd0, 4'd0, 1'b0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check("post-reset rdy", 32'(data_resultRDY), 32'd0);

    // Basic division and the pulse width
    do_one("7/2", 4'd7, 4'd2, 4'd3, 4'd1, 1'b0);
    @(negedge clock);
    check("7/2 rdy drop", 32'(data_resultRDY), 32'd0);

    // Sign matrix
    do_one("7/-3",  4'd7,     4'b1101, 4'b1110, 4'd1,    1'b0);
    do_one("-7/2",  4'b1001,  4'd2,    4'b1101, 4'b1111, 1'b0);
    do_one("-6/-3", 4'b1010,  4'b1101, 4'd2,    4'd0,    1'b0);

    // Exceptions
    do_one("5/0",   4'd5,    4'd0,    4'd0,    4'd5, 1'b1);
    do_one("-8/-1", 4'b1000, 4'b1111, 4'b1000, 4'd0, 1'b1);

    // Operand changes without a start leave the outputs alone
    data_operandA = 4'd1; data_operandB = 4'd1;
    @(negedge clock);
    data_operandA = 4'd3; data_operandB = 4'd2;
    @(negedge clock);
    check_result("hold", 1'b0, 4'b1000, 4'd0, 1'b1);

    // Start held high: rdy rises from the second cycle on
    @(negedge clock);
    ctrl_DIV = 1'b1; data_operandA = 4'd7; data_operandB = 4'd2;
    @(negedge clock);
    check("held c1 rdy", 32'(data_resultRDY), 32'd0);
    @(negedge clock);
    check_result("held c2", 1'b1, 4'd3, 4'd1, 1'b0);
    @(negedge clock);
    check_result("held c3", 1'b1, 4'd3, 4'd1, 1'b0);
    ctrl_DIV = 1'b0;
    @(negedge clock);
    check("held tail rdy", 32'(data_resultRDY), 32'd1);
    @(negedge clock);
    check("held end rdy", 32'(data_resultRDY), 32'd0);

    // Exhaustive back-to-back sweep
    for (int i = 0; i < 256; i++) begin
      @(negedge clock);
      if (i >= 2) begin
        e = exp_q.pop_front();
        check_result($sformatf("sweep %0d", i - 2), 1'b1, e[7:4], e[3:0], e[8]);
      end
      ab = i[7:0];
      ctrl_DIV = 1'b1; data_operandA = ab[7:4]; data_operandB = ab[3:0];
      exp_q.push_back(model(ab[7:4], ab[3:0]));
    end
    @(negedge clock);
    ctrl_DIV = 1'b0;
    e = exp_q.pop_front();
    check_result("sweep 254", 1'b1, e[7:4], e[3:0], e[8]);
    @(negedge clock);
    e = exp_q.pop_front();
    check_result("sweep 255", 1'b1, e[7:4], e[3:0], e[8]);
    @(negedge clock);
    check("sweep end rdy", 32'(data_resultRDY), 32'd0);
    check("sweep hold Q", 32'(Q), 32'd1);

    // Reset in flight discards the pending division
    @(negedge clock);
    ctrl_DIV = 1'b1; data_operandA = 4'd6; data_operandB = 4'd3;
    @(posedge clock);
    #2;
    ctrl_DIV = 1'b0;
    reset_n = 1'b0;
    #1;
    check_result("async reset", 1'b0, 4'd0, 4'd0, 1'b0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check("release rdy a", 32'(data_resultRDY), 32'd0);
    @(negedge clock);
    check_result("release b", 1'b0, 4'd0, 4'd0, 1'b0);
    do_one("6/3 after reset", 4'd6, 4'd3, 4'd2, 4'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
